wm8731_config_seq: RTL

Configuration sequencer directly upstream of the WM8731 I2C write engine. Walks a fixed table of 16-bit codec register words (7-bit register address, 9-bit data), presents one word at a time on the engine's DATA/ENABLE inputs and waits for the engine's FINISHED pulse before advancing. Runs once automatically after reset and again on request. Includes a per-word timeout with bounded retry so a hung bus cannot stall the bring-up forever.

---
 rtl/wm8731_cfg_pkg.sv | 45 ++++
 rtl/wm8731_cfg_rom.sv | 42 ++++
 rtl/wm8731_config_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/wm8731_cfg_pkg.sv
// Shared state type and WM8731 register word constants for the codec configuration sequencer.
package wm8731_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4,
    ST_FAIL = 3'd5
  } cfgState_t;

  localparam int CFG_NUM_WORDS = 10;
  localparam int CFG_MAX_WORDS = 11;

  localparam logic [6:0] REG_LEFT_LINE_IN   = 7'h00;
  localparam logic [6:0] REG_RIGHT_LINE_IN  = 7'h01;
  localparam logic [6:0] REG_LEFT_HP_OUT    = 7'h02;
  localparam logic [6:0] REG_RIGHT_HP_OUT   = 7'h03;
  localparam logic [6:0] REG_ANALOG_PATH    = 7'h04;
  localparam logic [6:0] REG_DIGITAL_PATH   = 7'h05;
  localparam logic [6:0] REG_POWER_DOWN     = 7'h06;
  localparam logic [6:0] REG_DIGITAL_IF     = 7'h07;
  localparam logic [6:0] REG_SAMPLING       = 7'h08;
  localparam logic [6:0] REG_ACTIVE         = 7'h09;
  localparam logic [6:0] REG_RESET          = 7'h0F;

  // Each word is the 7-bit register address followed by its 9-bit payload.
  function automatic logic [15:0] cfgWord(input logic [6:0] addr, input logic [8:0] data);
    return {addr, data};
  endfunction

  localparam logic [15:0] WORD_RESET        = {REG_RESET,         9'h000};
  localparam logic [15:0] WORD_LEFT_LINE    = {REG_LEFT_LINE_IN,  9'h017};
  localparam logic [15:0] WORD_RIGHT_LINE   = {REG_RIGHT_LINE_IN, 9'h017};
  localparam logic [15:0] WORD_LEFT_HP      = {REG_LEFT_HP_OUT,   9'h079};
  localparam logic [15:0] WORD_RIGHT_HP     = {REG_RIGHT_HP_OUT,  9'h079};
  localparam logic [15:0] WORD_ANALOG_PATH  = {REG_ANALOG_PATH,   9'h012};
  localparam logic [15:0] WORD_DIGITAL_PATH = {REG_DIGITAL_PATH,  9'h000};
  localparam logic [15:0] WORD_POWER_DOWN   = {REG_POWER_DOWN,    9'h000};
  localparam logic [15:0] WORD_DIGITAL_IF   = {REG_DIGITAL_IF,    9'h002};
  localparam logic [15:0] WORD_SAMPLING     = {REG_SAMPLING,      9'h000};
  localparam logic [15:0] WORD_ACTIVE       = {REG_ACTIVE,        9'h001};

endpackage

// File: rtl/wm8731_cfg_rom.sv
// Combinational lookup from table index to codec register word; out-of-range indices give zero.
module wm8731_cfg_rom
  import wm8731_cfg_pkg::*;
#(
  parameter int NUM_WORDS = CFG_NUM_WORDS
) (
  input  logic [4:0]  i_idx,
  output logic [15:0] o_word
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_WORDS - 1);

  logic [15:0] w_baseWord;

  always_comb begin
    w_baseWord = 16'h0000;
    case (i_idx)
      5'd0:    w_baseWord = WORD_RESET;
      5'd1:    w_baseWord = WORD_LEFT_LINE;
      5'd2:    w_baseWord = WORD_RIGHT_LINE;
      5'd3:    w_baseWord = WORD_LEFT_HP;
      5'd4:    w_baseWord = WORD_RIGHT_HP;
      5'd5:    w_baseWord = WORD_ANALOG_PATH;
      5'd6:    w_baseWord = WORD_DIGITAL_PATH;
      5'd7:    w_baseWord = WORD_POWER_DOWN;
      5'd8:    w_baseWord = WORD_DIGITAL_IF;
      5'd9:    w_baseWord = WORD_SAMPLING;
      default: w_baseWord = 16'h0000;
    endcase
  end

  // Activation must come last, so it overrides whatever base entry sits at the final index.
  always_comb begin
    o_word = 16'h0000;
    if (i_idx == LAST_IDX) begin
      o_word = WORD_ACTIVE;
    end else if (i_idx < LAST_IDX) begin
      o_word = w_baseWord;
    end
  end

endmodule

// File: rtl/wm8731_config_seq.sv
// Walks the codec register table into the I2C write engine, one word per ENABLE pulse,
// with a per-word timeout and bounded retry.
module wm8731_config_seq
  import wm8731_cfg_pkg::*;
#(
  parameter int NUM_WORDS      = CFG_NUM_WORDS,
  parameter int GAP_CYCLES     = 2048,
  parameter int TIMEOUT_CYCLES = 32768,
  parameter int MAX_RETRY      = 3
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        FINISHED,
  output logic        ENABLE,
  output logic [15:0] DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [3:0]  WORD_IDX
);

  localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  IDX_END      = 5'(NUM_WORDS);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

  cfgState_t   r_state;
  cfgState_t   w_stateNext;
  logic [4:0]  r_idx;
  logic [4:0]  w_idxNext;
  logic [3:0]  r_retry;
  logic [3:0]  w_retryNext;
  logic [15:0] r_cnt;
  logic [15:0] w_cntNext;
  logic        r_pending;
  logic        w_pendingNext;
  logic        r_finQ;
  logic [15:0] r_data;
  logic [15:0] w_dataNext;
  logic [3:0]  r_wordIdx;
  logic [3:0]  w_wordIdxNext;
  logic        r_enable;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic        w_finRise;
  logic        w_timeout;
  logic        w_gapEnd;
  logic        w_lastRetry;
  logic [15:0] w_romWord;

  wm8731_cfg_rom #(
    .NUM_WORDS(NUM_WORDS)
  ) u_rom (
    .i_idx (r_idx),
    .o_word(w_romWord)
  );

  // A held FINISHED level must count once, so only the edge against the registered copy matters.
  assign w_finRise   = FINISHED & ~r_finQ;
  assign w_timeout   = (r_cnt == TIMEOUT_LAST);
  assign w_gapEnd    = (r_cnt == GAP_LAST);
  assign w_lastRetry = (r_retry == RETRY_MAX);

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_pending || START) w_stateNext = ST_LOAD;
      end
      ST_LOAD: begin
        w_stateNext = ST_SEND;
      end
      ST_SEND: begin
        if (w_finRise) begin
          w_stateNext = ST_GAP;
        end else if (w_timeout) begin
          w_stateNext = w_lastRetry ? ST_FAIL : ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_gapEnd) w_stateNext = (r_idx == IDX_END) ? ST_DONE : ST_LOAD;
      end
      ST_DONE, ST_FAIL: begin
        if (START) w_stateNext = ST_LOAD;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_idxNext     = r_idx;
    w_retryNext   = r_retry;
    w_cntNext     = r_cnt;
    w_pendingNext = r_pending;
    w_dataNext    = r_data;
    w_wordIdxNext = r_wordIdx;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (w_stateNext == ST_LOAD) begin
          w_idxNext     = 5'd0;
          w_retryNext   = 4'd0;
          w_cntNext     = 16'd0;
          w_pendingNext = 1'b0;
        end
      end
      ST_LOAD: begin
        w_dataNext    = w_romWord;
        w_wordIdxNext = r_idx[3:0];
        w_cntNext     = 16'd0;
      end
      ST_SEND: begin
        if (w_finRise) begin
          w_idxNext   = r_idx + 5'd1;
          w_retryNext = 4'd0;
          w_cntNext   = 16'd0;
        end else if (w_timeout) begin
          if (!w_lastRetry) w_retryNext = r_retry + 4'd1;
          w_cntNext = 16'd0;
        end else begin
          w_cntNext = r_cnt + 16'd1;
        end
      end
      ST_GAP: begin
        w_cntNext = w_gapEnd ? 16'd0 : r_cnt + 16'd1;
      end
      default: begin
        w_cntNext = 16'd0;
      end
    endcase
  end

  // Status flags follow the registered state, so ENABLE drops one cycle after leaving SEND.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_idx     <= 5'd0;
      r_retry   <= 4'd0;
      r_cnt     <= 16'd0;
      r_pending <= 1'b1;
      r_finQ    <= 1'b0;
      r_data    <= 16'h0000;
      r_wordIdx <= 4'd0;
      r_enable  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_idx     <= w_idxNext;
      r_retry   <= w_retryNext;
      r_cnt     <= w_cntNext;
      r_pending <= w_pendingNext;
      r_finQ    <= FINISHED;
      r_data    <= w_dataNext;
      r_wordIdx <= w_wordIdxNext;
      r_enable  <= (r_state == ST_SEND);
      r_busy    <= (r_state == ST_LOAD) || (r_state == ST_SEND) || (r_state == ST_GAP);
      r_done    <= (r_state == ST_DONE);
      r_error   <= (r_state == ST_FAIL);
    end
  end

  assign ENABLE   = r_enable;
  assign DATA     = r_data;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign ERROR    = r_error;
  assign WORD_IDX = r_wordIdx;

endmodule
